// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 boot-time register sequencer.
// Table entries are 32-bit words {op, sub_addr, data}. The opcodes are
// WRITE (write data to sub_addr), DELAY (wait data ms) and END (sequence
// complete); any other opcode is a fatal table error.
// Optional feature macro: SCCB_VERIFY_EN adds the read-back verify states.
package ov5640_pkg;

    localparam logic [7:0] OP_WRITE = 8'h00;
    localparam logic [7:0] OP_DELAY = 8'h01;
    localparam logic [7:0] OP_END   = 8'hFF;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] sub_addr;
        logic [7:0]  data;
    } init_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRWAIT,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_ACK_WAIT,
        ST_DELAY,
        ST_NEXT,
        ST_DONE,
        ST_FAIL
`ifdef SCCB_VERIFY_EN
        ,
        ST_VERIFY,
        ST_VWAIT
`endif
    } state_t;

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer shared by the power-up wait and the table DELAY entries.
// A prescaler produces a tick every CLK_FREQ_HZ/1000 clocks; a down-counter
// loaded with a millisecond count decrements on each tick and raises zero
// once it reaches 0. Loading also clears the prescaler, so the first
// millisecond after a load is a full millisecond.
// Ports:
//   clk, rest_n   system clock, asynchronous active-low reset
//   load          load load_val into the ms counter and restart the prescaler
//   load_val      millisecond count to load
//   zero          ms counter is 0
module ms_timer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rest_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    localparam int DIV = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
    localparam int PW  = $clog2(DIV + 1);

    logic [PW-1:0] presc;
    logic [CW-1:0] ms_cnt;
    logic          tick;

    assign tick = (presc == PW'(DIV - 1));
    assign zero = (ms_cnt == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (load) begin
            presc  <= '0;
            ms_cnt <= load_val;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && !zero) begin
                ms_cnt <= ms_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ov5640_init_sequencer.sv
// OV5640 boot-time register sequencer. Walks a table of 32-bit entries and
// drives the SCCB controller command interface: one write per WRITE entry,
// millisecond waits for DELAY entries, stop on END or after the last entry.
// NACKed writes are retried up to MAX_RETRY times before giving up.
// Optional feature macro: SCCB_VERIFY_EN -- each acknowledged write is read
// back and compared; a mismatch counts as a failed attempt.
// Ports:
//   clk, rest_n          system clock, asynchronous active-low reset
//   start                one-cycle pulse, accepted in IDLE/DONE/FAIL
//   busy                 sequence running
//   init_done/init_fail  sticky completion flags; fail_index = failing entry
//   tbl_index/tbl_entry  table read port (one cycle read latency)
//   device_addr, sub_addr, write, read, write_data   SCCB command side
//   request_done, error, read_data, resp_valid        SCCB status side
//   resp_ready           always ready for responses
module ov5640_init_sequencer
    import ov5640_pkg::*;
#(
    parameter int          CLK_FREQ_HZ    = 50_000_000,
    parameter logic [7:0]  DEVICE_ADDR    = 8'h78,
    parameter int          TABLE_DEPTH    = 256,
    parameter int          MAX_RETRY      = 3,
    parameter int          START_DELAY_MS = 20,
    localparam int         IW             = $clog2(TABLE_DEPTH)
) (
    input  logic          clk,
    input  logic          rest_n,
    input  logic          start,
    output logic          busy,
    output logic          init_done,
    output logic          init_fail,
    output logic [IW-1:0] fail_index,
    output logic [IW-1:0] tbl_index,
    input  logic [31:0]   tbl_entry,
    output logic [7:0]    device_addr,
    output logic [15:0]   sub_addr,
    output logic          write,
    output logic          read,
    output logic [7:0]    write_data,
    input  logic          request_done,
    input  logic [7:0]    read_data,
    input  logic          resp_valid,
    output logic          resp_ready,
    input  logic          error
);

    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t        state;
    init_entry_t   ent;
    logic [RW-1:0] retry_cnt;
    logic          seen_busy;   // controller has dropped request_done since our pulse
    logic          tmr_load;
    logic [15:0]   tmr_val;
    logic          tmr_zero;

    assign ent         = init_entry_t'(tbl_entry);
    assign device_addr = DEVICE_ADDR;
    assign resp_ready  = 1'b1;

    // The timer is loaded on the same edge that enters PWRWAIT or DELAY, so
    // the first cycle in those states already sees the loaded count.
    // NOTE: every output of this block gets a default first; otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = 16'(START_DELAY_MS);
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: tmr_load = start;
            ST_DECODE: begin
                if (ent.op == OP_DELAY) begin
                    tmr_load = 1'b1;
                    tmr_val  = {8'h00, ent.data};
                end
            end
            default: ;
        endcase
    end

    ms_timer #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .CW         (16)
    ) u_ms_timer (
        .clk     (clk),
        .rest_n  (rest_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

`ifdef SCCB_VERIFY_EN
    logic read_q;
    assign read = read_q;
`else
    logic unused_verify;
    assign read          = 1'b0;
    assign unused_verify = ^{read_data, resp_valid};
`endif

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            init_fail  <= 1'b0;
            fail_index <= '0;
            tbl_index  <= '0;
            sub_addr   <= '0;
            write_data <= '0;
            write      <= 1'b0;
            retry_cnt  <= '0;
            seen_busy  <= 1'b0;
`ifdef SCCB_VERIFY_EN
            read_q     <= 1'b0;
`endif
        end else begin
            write <= 1'b0;
`ifdef SCCB_VERIFY_EN
            read_q <= 1'b0;
`endif
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state     <= ST_PWRWAIT;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        init_fail <= 1'b0;
                        tbl_index <= '0;
                        retry_cnt <= '0;
                    end
                end
                ST_PWRWAIT: if (tmr_zero) state <= ST_FETCH;
                ST_FETCH:   state <= ST_DECODE;
                ST_DECODE: begin
                    sub_addr   <= ent.sub_addr;
                    write_data <= ent.data;
                    case (ent.op)
                        OP_WRITE: state <= ST_ISSUE;
                        OP_DELAY: state <= ST_DELAY;
                        OP_END: begin
                            state     <= ST_DONE;
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                        end
                        default: begin
                            state      <= ST_FAIL;
                            init_fail  <= 1'b1;
                            busy       <= 1'b0;
                            fail_index <= tbl_index;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (request_done) begin
                        write     <= 1'b1;
                        seen_busy <= 1'b0;
                        state     <= ST_ACK_WAIT;
                    end
                end
                ST_ACK_WAIT: begin
                    // request_done is still high from before the pulse; only
                    // its return after going low marks completion.
                    if (!seen_busy) begin
                        if (!request_done) seen_busy <= 1'b1;
                    end else if (request_done) begin
                        if (!error) begin
`ifdef SCCB_VERIFY_EN
                            state <= ST_VERIFY;
`else
                            state <= ST_NEXT;
`endif
                        end else if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= ST_ISSUE;
                        end else begin
                            state      <= ST_FAIL;
                            init_fail  <= 1'b1;
                            busy       <= 1'b0;
                            fail_index <= tbl_index;
                        end
                    end
                end
`ifdef SCCB_VERIFY_EN
                ST_VERIFY: begin
                    if (request_done) begin
                        read_q <= 1'b1;
                        state  <= ST_VWAIT;
                    end
                end
                ST_VWAIT: begin
                    if (resp_valid) begin
                        if (!error && read_data == write_data) begin
                            state <= ST_NEXT;
                        end else if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= ST_ISSUE;
                        end else begin
                            state      <= ST_FAIL;
                            init_fail  <= 1'b1;
                            busy       <= 1'b0;
                            fail_index <= tbl_index;
                        end
                    end
                end
`endif
                ST_DELAY: if (tmr_zero) state <= ST_NEXT;
                ST_NEXT: begin
                    retry_cnt <= '0;
                    // Running off the end of the table without END is a success.
                    if (tbl_index == IW'(TABLE_DEPTH - 1)) begin
                        state     <= ST_DONE;
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        tbl_index <= tbl_index + IW'(1);
                        state     <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Self-checking bench for ov5640_init_sequencer. A table ROM model (one cycle
// latency) and an SCCB controller model with programmable NACKs / corrupted
// read-backs surround the DUT; a table-walking reference model predicts the
// command stream and the final status for directed vectors and random tables.
module tb_ov5640_init_sequencer;
    import ov5640_pkg::*;

    localparam int CLK_HZ = 10_000;   // 10 clocks per ms
    localparam int DEPTH  = 16;
    localparam int RETRY  = 3;
    localparam int SDLY   = 2;
    localparam int IW     = 4;
    localparam int TICK   = 10;
    localparam int ALWAYS = 99;       // NACK budget meaning "never ACK"

    typedef logic [24:0] op_t;        // {is_read, sub_addr, data}

    typedef struct {
        logic [31:0] e0, e1, e2, e3;
        int          nk0, nk1;
        bit          done;
        int          fidx;
        int          tidx;
        int          nwr;
    } vec_t;

    logic clk = 1'b0, rest_n = 1'b0, start = 1'b0;
    logic busy, init_done, init_fail, write, read, resp_ready;
    logic [IW-1:0] fail_index, tbl_index;
    logic [31:0] tbl_entry = '0;
    logic [7:0]  device_addr, write_data, read_data;
    logic [15:0] sub_addr;
    logic request_done, resp_valid, error;

    ov5640_init_sequencer #(
        .CLK_FREQ_HZ(CLK_HZ), .DEVICE_ADDR(8'h78), .TABLE_DEPTH(DEPTH),
        .MAX_RETRY(RETRY), .START_DELAY_MS(SDLY)
    ) dut (
        .clk(clk), .rest_n(rest_n), .start(start), .busy(busy),
        .init_done(init_done), .init_fail(init_fail), .fail_index(fail_index),
        .tbl_index(tbl_index), .tbl_entry(tbl_entry), .device_addr(device_addr),
        .sub_addr(sub_addr), .write(write), .read(read), .write_data(write_data),
        .request_done(request_done), .read_data(read_data), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .error(error)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int cyc = 0, viol = 0, start_cyc = 0;
    logic [31:0] tbl [DEPTH];
    int  nack_cfg [DEPTH];
    int  nack_left [DEPTH];
    int  corrupt_cfg = 0, corrupt_left = 0;
    logic [7:0] mem [65536];
    op_t ops_log[$], exp_ops[$];
    int  wr_cyc[$];
    bit  exp_done, exp_fail;
    int  exp_idx;
    bit  prev_w = 0, prev_r = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    always @(posedge clk) cyc++;

    // Table ROM: tbl_entry shows the entry addressed one cycle earlier.
    initial begin
        logic [31:0] rom_q;
        rom_q = '0;
        forever begin
            @(posedge clk); #1;
            tbl_entry = rom_q;
            rom_q = tbl[tbl_index];
        end
    end

    // SCCB controller model.
    initial begin
        bit          is_rd;
        int          idx;
        logic [15:0] a;
        logic [7:0]  d;
        request_done = 1'b1; error = 1'b0; resp_valid = 1'b0; read_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rest_n && (write || read)) begin
                is_rd = read; idx = int'(tbl_index); a = sub_addr; d = write_data;
                request_done = 1'b0; error = 1'b0;
                repeat ($urandom_range(2, 5)) @(posedge clk);
                #1;
                if (is_rd) begin
                    read_data = (corrupt_left > 0) ? (mem[a] ^ 8'h03) : mem[a];
                    if (corrupt_left > 0) corrupt_left--;
                    resp_valid = 1'b1;
                end else if (nack_left[idx] > 0) begin
                    error = 1'b1;
                    if (nack_left[idx] != ALWAYS) nack_left[idx]--;
                end else begin
                    mem[a] = d;
                end
                request_done = 1'b1;
                if (is_rd) begin
                    @(posedge clk); #1;
                    resp_valid = 1'b0;
                end
            end
        end
    end

    // Command monitor: logs pulses and counts pulse-shape violations.
    always @(negedge clk) begin
        if (write && read) viol++;
        if ((write && prev_w) || (read && prev_r)) viol++;
        prev_w = write;
        prev_r = read;
        if (write) begin
            ops_log.push_back({1'b0, sub_addr, write_data});
            wr_cyc.push_back(cyc);
        end
        if (read) ops_log.push_back({1'b1, sub_addr, write_data});
    end

    // Reference: walk the table entry by entry, applying the retry budget.
    function automatic void ref_model();
        int          nk [DEPTH];
        int          cr, idx;
        bit          fin, ok;
        init_entry_t e;
        exp_ops.delete();
        exp_done = 0; exp_fail = 0;
        cr = corrupt_cfg;
        for (int i = 0; i < DEPTH; i++) nk[i] = nack_cfg[i];
        idx = 0; fin = 0;
        while (!fin) begin
            e = init_entry_t'(tbl[idx]);
            if (e.op == OP_WRITE) begin
                ok = 0;
                for (int att = 0; att <= RETRY && !ok; att++) begin
                    exp_ops.push_back({1'b0, e.sub_addr, e.data});
                    if (nk[idx] > 0) begin
                        if (nk[idx] != ALWAYS) nk[idx]--;
                    end else begin
                        ok = 1;
`ifdef SCCB_VERIFY_EN
                        exp_ops.push_back({1'b1, e.sub_addr, e.data});
                        if (cr > 0) begin
                            cr--;
                            ok = 0;
                        end
`endif
                    end
                end
                if (!ok) begin exp_fail = 1; fin = 1; end
            end else if (e.op == OP_END) begin
                exp_done = 1; fin = 1;
            end else if (e.op != OP_DELAY) begin
                exp_fail = 1; fin = 1;
            end
            if (!fin) begin
                if (idx == DEPTH - 1) begin exp_done = 1; fin = 1; end
                else idx++;
            end
        end
        exp_idx = idx;
    endfunction

    task automatic run(input string tag, input int inject_at);
        int n;
        ops_log.delete(); wr_cyc.delete();
        nack_left = nack_cfg;
        corrupt_left = corrupt_cfg;
        ref_model();
        @(negedge clk); start = 1'b1; start_cyc = cyc;
        @(negedge clk); start = 1'b0;
        check({tag, " busy_set"}, busy, 1);
        n = 0;
        while (busy && n < 20000) begin
            start = (n == inject_at);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, " no_timeout"}, (n < 20000), 1);
        repeat (8) @(negedge clk);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " init_done"}, init_done, exp_done);
        check({tag, " init_fail"}, init_fail, exp_fail);
        check({tag, " tbl_index"}, tbl_index, exp_idx);
        if (exp_fail) check({tag, " fail_index"}, fail_index, exp_idx);
        check({tag, " op_count"}, ops_log.size(), exp_ops.size());
        for (int i = 0; i < exp_ops.size() && i < ops_log.size(); i++)
            check({tag, " op"}, ops_log[i], exp_ops[i]);
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [15:0] a, input logic [7:0] d);
        return {op, a, d};
    endfunction

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < DEPTH; i++) begin
            tbl[i] = mk(OP_END, 16'h0, 8'h0);
            nack_cfg[i] = 0;
        end
        tbl[0] = v.e0; tbl[1] = v.e1; tbl[2] = v.e2; tbl[3] = v.e3;
        nack_cfg[0] = v.nk0; nack_cfg[1] = v.nk1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, init_done, 0);
        check({tag, " fail"}, init_fail, 0);
        check({tag, " write"}, write, 0);
        check({tag, " read"}, read, 0);
        check({tag, " tbl_index"}, tbl_index, 0);
        check({tag, " fail_index"}, fail_index, 0);
        check({tag, " sub_addr"}, sub_addr, 0);
        check({tag, " write_data"}, write_data, 0);
        check({tag, " device_addr"}, device_addr, 8'h78);
        check({tag, " resp_ready"}, resp_ready, 1);
    endtask

    vec_t vecs [4];

    initial begin
        int nw, len, r;
        vecs[0] = '{mk(OP_WRITE,16'h3008,8'h82), mk(OP_DELAY,16'h0,8'd5),
                    mk(OP_WRITE,16'h3103,8'h03), mk(OP_END,16'h0,8'h0), 0, 0, 1, 0, 3, 2};
        vecs[1] = '{mk(OP_WRITE,16'h3008,8'h82), mk(OP_DELAY,16'h0,8'd5),
                    mk(OP_WRITE,16'h3103,8'h03), mk(OP_END,16'h0,8'h0), 2, 0, 1, 0, 3, 4};
        vecs[2] = '{mk(OP_WRITE,16'h3008,8'h82), mk(OP_WRITE,16'h3103,8'h03),
                    mk(OP_END,16'h0,8'h0), mk(OP_END,16'h0,8'h0), 0, ALWAYS, 0, 1, 1, 5};
        vecs[3] = '{mk(8'h42,16'h3008,8'h82), mk(OP_WRITE,16'h3103,8'h03),
                    mk(OP_END,16'h0,8'h0), mk(OP_END,16'h0,8'h0), 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < DEPTH; i++) begin tbl[i] = '0; nack_cfg[i] = 0; nack_left[i] = 0; end

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rest_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            load_vec(vecs[v]);
            run($sformatf("vec%0d", v), -1);
            nw = 0;
            foreach (ops_log[i]) if (!ops_log[i][24]) nw++;
            check($sformatf("vec%0d writes", v), nw, vecs[v].nwr);
            check($sformatf("vec%0d done_const", v), init_done, vecs[v].done);
            check($sformatf("vec%0d tidx_const", v), tbl_index, vecs[v].tidx);
            if (!vecs[v].done) check($sformatf("vec%0d fidx_const", v), fail_index, vecs[v].fidx);
            if (v == 0 && wr_cyc.size() == 2) begin
                check("vec0 start_delay", (wr_cyc[0] - start_cyc >= SDLY * TICK), 1);
                check("vec0 ms_gap_min", (wr_cyc[1] - wr_cyc[0] >= 5 * TICK), 1);
                check("vec0 ms_gap_max", (wr_cyc[1] - wr_cyc[0] <= 5 * TICK + 30), 1);
            end
        end

        // Reset in the middle of a write handshake, then a clean restart.
        load_vec(vecs[0]);
        nack_left = nack_cfg;
        ops_log.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nw = 0;
        while (ops_log.size() == 0 && nw < 2000) begin @(negedge clk); nw++; end
        check("midrst saw_write", (ops_log.size() > 0), 1);
        @(negedge clk);
        rest_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (3) @(negedge clk);
        rest_n = 1'b1;
        repeat (10) @(negedge clk);
        run("restart", -1);

`ifdef SCCB_VERIFY_EN
        load_vec(vecs[0]);
        tbl[0] = mk(OP_WRITE, 16'h3008, 8'h82);
        tbl[1] = mk(OP_END, 16'h0, 8'h0);
        corrupt_cfg = 1;
        run("verify", -1);
        check("verify n_ops", ops_log.size(), 4);
        if (ops_log.size() == 4) begin
            check("verify op0", ops_log[0], {1'b0, 16'h3008, 8'h82});
            check("verify op1", ops_log[1], {1'b1, 16'h3008, 8'h82});
            check("verify op2", ops_log[2], {1'b0, 16'h3008, 8'h82});
            check("verify op3", ops_log[3], {1'b1, 16'h3008, 8'h82});
        end
        check("verify done", init_done, 1);
`endif

        // Random tables, with a stray start pulse while busy.
        for (int k = 0; k < 15; k++) begin
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                r = $urandom_range(0, 19);
                if (r < 12)      tbl[i] = mk(OP_WRITE, 16'($urandom), 8'($urandom));
                else if (r < 18) tbl[i] = mk(OP_DELAY, 16'($urandom), 8'($urandom_range(0, 2)));
                else if (r < 19) tbl[i] = mk(8'($urandom_range(2, 254)), 16'h0, 8'h0);
                else             tbl[i] = mk(OP_WRITE, 16'h4300, 8'h30);
                nack_cfg[i] = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 4);
            end
            if (len < DEPTH) tbl[len] = mk(OP_END, 16'h0, 8'h0);
`ifdef SCCB_VERIFY_EN
            corrupt_cfg = $urandom_range(0, 1);
`else
            corrupt_cfg = 0;
`endif
            run($sformatf("rand%0d", k), $urandom_range(30, 150));
        end

        check("pulse_protocol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
